// File: rtl/gpu_raster_if.sv
// Command and framebuffer-port bundle for the raster engine.
// The slave modport is the engine side; the master modport is the decoder/RAM side.
interface gpu_raster_if #(
    parameter int unsigned XW = 9,
    parameter int unsigned YW = 8
);
    logic          cmd_valid;
    logic          cmd_ready;
    logic          cmd_op;
    logic [1:0]    cmd_rop;
    logic          fill_value;
    logic [XW-1:0] src_x;
    logic [YW-1:0] src_y;
    logic [XW-1:0] dst_x;
    logic [YW-1:0] dst_y;
    logic [XW-1:0] rect_w;
    logic [YW-1:0] rect_h;
    logic          abort;
    logic [XW-1:0] mem_x;
    logic [YW-1:0] mem_y;
    logic          mem_rd_en;
    logic          mem_rd_data;
    logic          mem_wr_en;
    logic          mem_wr_data;
    logic          busy;
    logic          done;
    logic          error;
    logic [1:0]    err_code;

    modport slave (
        input  cmd_valid, cmd_op, cmd_rop, fill_value, src_x, src_y, dst_x, dst_y,
               rect_w, rect_h, abort, mem_rd_data,
        output cmd_ready, mem_x, mem_y, mem_rd_en, mem_wr_en, mem_wr_data,
               busy, done, error, err_code
    );

    modport master (
        output cmd_valid, cmd_op, cmd_rop, fill_value, src_x, src_y, dst_x, dst_y,
               rect_w, rect_h, abort, mem_rd_data,
        input  cmd_ready, mem_x, mem_y, mem_rd_en, mem_wr_en, mem_wr_data,
               busy, done, error, err_code
    );
endinterface

// File: rtl/gpu_raster_engine.sv
// 1-bpp framebuffer engine: rectangle FILL and overlap-safe BLIT with raster ops.
// Owns the framebuffer RAM port while busy; one pixel at a time.
module gpu_raster_engine #(
    parameter int unsigned WIDTH  = 320,
    parameter int unsigned HEIGHT = 200,
    parameter int unsigned XW     = 9,
    parameter int unsigned YW     = 8,
    parameter int unsigned RD_LAT = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    gpu_raster_if.slave bus
);

    localparam int unsigned WCW = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
    localparam logic [1:0]  ROP_COPY = 2'd0;
    localparam logic [1:0]  ROP_XOR  = 2'd1;
    localparam logic [1:0]  ROP_AND  = 2'd2;
    localparam logic [1:0]  ROP_OR   = 2'd3;
    localparam logic        OP_BLIT  = 1'b1;

    typedef enum logic [2:0] {
        IDLE, RD_SRC, WAIT_SRC, RD_DST, WAIT_DST, WRITE
    } state_t;

    typedef struct packed {
        logic          op;
        logic [1:0]    rop;
        logic [XW-1:0] src_x;
        logic [YW-1:0] src_y;
        logic [XW-1:0] dst_x;
        logic [YW-1:0] dst_y;
        logic [XW-1:0] w;
        logic [YW-1:0] h;
    } cmd_t;

    function automatic logic rop_apply(input logic [1:0] r, input logic s, input logic d);
        case (r)
            ROP_XOR: return s ^ d;
            ROP_AND: return s & d;
            ROP_OR:  return s | d;
            default: return s;
        endcase
    endfunction

    // Entry state of each pixel: source read for BLIT, else dest read unless COPY.
    function automatic state_t first_state(input cmd_t c);
        if (c.op == OP_BLIT)       return RD_SRC;
        else if (c.rop != ROP_COPY) return RD_DST;
        else                        return WRITE;
    endfunction

    state_t        state_q, state_n;
    cmd_t          cmd_q, cmd_n, cmd_in, cur;
    logic [XW-1:0] xi_q, xi_n, x_off;
    logic [YW-1:0] yi_q, yi_n, y_off;
    logic [WCW-1:0] wait_q, wait_n;
    logic          s_q, s_n, d_q, d_n;
    logic          xrev, yrev, zero_size, out_of_bounds;
    logic          last_x, last_y, wait_last;

    logic [XW-1:0] mem_x_q, mem_x_n;
    logic [YW-1:0] mem_y_q, mem_y_n;
    logic          rd_en_q, rd_en_n, wr_en_q, wr_en_n, wr_data_q, wr_data_n;
    logic          busy_q, busy_n, ready_q, ready_n, done_q, done_n;
    logic          error_q, error_n;
    logic [1:0]    code_q, code_n;

    // Command view: live inputs while idle, latched copy once running.
    always_comb begin
        cmd_in.op    = bus.cmd_op;
        cmd_in.rop   = bus.cmd_rop;
        cmd_in.src_x = bus.src_x;
        cmd_in.src_y = bus.src_y;
        cmd_in.dst_x = bus.dst_x;
        cmd_in.dst_y = bus.dst_y;
        cmd_in.w     = bus.rect_w;
        cmd_in.h     = bus.rect_h;
        cur          = (state_q == IDLE) ? cmd_in : cmd_q;
        xrev         = (cur.op == OP_BLIT) && (cur.dst_x > cur.src_x);
        yrev         = (cur.op == OP_BLIT) && (cur.dst_y > cur.src_y);
        zero_size    = (cmd_in.w == '0) || (cmd_in.h == '0);
        out_of_bounds =
            (({1'b0, cmd_in.dst_x} + {1'b0, cmd_in.w}) > (XW+1)'(WIDTH))  ||
            (({1'b0, cmd_in.dst_y} + {1'b0, cmd_in.h}) > (YW+1)'(HEIGHT)) ||
            ((cmd_in.op == OP_BLIT) &&
             ((({1'b0, cmd_in.src_x} + {1'b0, cmd_in.w}) > (XW+1)'(WIDTH)) ||
              (({1'b0, cmd_in.src_y} + {1'b0, cmd_in.h}) > (YW+1)'(HEIGHT))));
        last_x    = (xi_q == (cmd_q.w - XW'(1)));
        last_y    = (yi_q == (cmd_q.h - YW'(1)));
        wait_last = (wait_q == WCW'(RD_LAT - 1));
    end

    // Next-state and datapath sequencing.
    always_comb begin
        state_n = state_q;
        cmd_n   = cmd_q;
        xi_n    = xi_q;
        yi_n    = yi_q;
        wait_n  = wait_q;
        s_n     = s_q;
        d_n     = d_q;
        done_n  = 1'b0;
        error_n = error_q;
        code_n  = code_q;

        case (state_q)
            IDLE: begin
                if (bus.cmd_valid) begin
                    if (zero_size) begin
                        done_n  = 1'b1;
                        error_n = 1'b1;
                        code_n  = 2'd2;
                    end else if (out_of_bounds) begin
                        done_n  = 1'b1;
                        error_n = 1'b1;
                        code_n  = 2'd1;
                    end else begin
                        cmd_n   = cmd_in;
                        xi_n    = '0;
                        yi_n    = '0;
                        wait_n  = '0;
                        s_n     = bus.fill_value;
                        error_n = 1'b0;
                        code_n  = 2'd0;
                        state_n = first_state(cmd_in);
                    end
                end
            end
            RD_SRC: begin
                wait_n  = '0;
                state_n = WAIT_SRC;
            end
            WAIT_SRC: begin
                if (wait_last) begin
                    s_n     = bus.mem_rd_data;
                    state_n = (cmd_q.rop == ROP_COPY) ? WRITE : RD_DST;
                end else begin
                    wait_n = wait_q + WCW'(1);
                end
            end
            RD_DST: begin
                wait_n  = '0;
                state_n = WAIT_DST;
            end
            WAIT_DST: begin
                if (wait_last) begin
                    d_n     = bus.mem_rd_data;
                    state_n = WRITE;
                end else begin
                    wait_n = wait_q + WCW'(1);
                end
            end
            WRITE: begin
                if (last_x && last_y) begin
                    done_n  = 1'b1;
                    error_n = 1'b0;
                    code_n  = 2'd0;
                    state_n = IDLE;
                end else begin
                    if (last_x) begin
                        xi_n = '0;
                        yi_n = yi_q + YW'(1);
                    end else begin
                        xi_n = xi_q + XW'(1);
                    end
                    state_n = first_state(cmd_q);
                end
            end
            default: state_n = IDLE;
        endcase

        if ((state_q != IDLE) && bus.abort) begin
            state_n = IDLE;
            done_n  = 1'b1;
            error_n = 1'b1;
            code_n  = 2'd3;
        end
    end

    // Registered RAM-port and status values for the state being entered.
    always_comb begin
        x_off     = xrev ? (cur.w - XW'(1) - xi_n) : xi_n;
        y_off     = yrev ? (cur.h - YW'(1) - yi_n) : yi_n;
        mem_x_n   = mem_x_q;
        mem_y_n   = mem_y_q;
        case (state_n)
            RD_SRC: begin
                mem_x_n = cur.src_x + x_off;
                mem_y_n = cur.src_y + y_off;
            end
            RD_DST, WRITE: begin
                mem_x_n = cur.dst_x + x_off;
                mem_y_n = cur.dst_y + y_off;
            end
            default: ;
        endcase
        rd_en_n   = (state_n == RD_SRC) || (state_n == RD_DST);
        wr_en_n   = (state_n == WRITE);
        wr_data_n = wr_en_n ? rop_apply(cur.rop, s_n, d_n) : 1'b0;
        busy_n    = (state_n != IDLE);
        ready_n   = (state_n == IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            cmd_q     <= '0;
            xi_q      <= '0;
            yi_q      <= '0;
            wait_q    <= '0;
            s_q       <= 1'b0;
            d_q       <= 1'b0;
            mem_x_q   <= '0;
            mem_y_q   <= '0;
            rd_en_q   <= 1'b0;
            wr_en_q   <= 1'b0;
            wr_data_q <= 1'b0;
            busy_q    <= 1'b0;
            ready_q   <= 1'b1;
            done_q    <= 1'b0;
            error_q   <= 1'b0;
            code_q    <= 2'd0;
        end else begin
            state_q   <= state_n;
            cmd_q     <= cmd_n;
            xi_q      <= xi_n;
            yi_q      <= yi_n;
            wait_q    <= wait_n;
            s_q       <= s_n;
            d_q       <= d_n;
            mem_x_q   <= mem_x_n;
            mem_y_q   <= mem_y_n;
            rd_en_q   <= rd_en_n;
            wr_en_q   <= wr_en_n;
            wr_data_q <= wr_data_n;
            busy_q    <= busy_n;
            ready_q   <= ready_n;
            done_q    <= done_n;
            error_q   <= error_n;
            code_q    <= code_n;
        end
    end

    assign bus.cmd_ready   = ready_q;
    assign bus.mem_x       = mem_x_q;
    assign bus.mem_y       = mem_y_q;
    assign bus.mem_rd_en   = rd_en_q;
    assign bus.mem_wr_en   = wr_en_q;
    assign bus.mem_wr_data = wr_data_q;
    assign bus.busy        = busy_q;
    assign bus.done        = done_q;
    assign bus.error       = error_q;
    assign bus.err_code    = code_q;

endmodule

// File: tb/tb_gpu_raster_engine.sv
// Scoreboard bench for gpu_raster_engine: expected strobes/completions are queued at issue
// time and a forked monitor pops and compares them as the DUT presents them.
module tb_gpu_raster_engine;
    localparam int unsigned WIDTH  = 320;
    localparam int unsigned HEIGHT = 200;
    localparam int unsigned XW     = 9;
    localparam int unsigned YW     = 8;
    localparam int unsigned RD_LAT = 1;
    localparam int          NPIX   = WIDTH * HEIGHT;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    gpu_raster_if #(.XW(XW), .YW(YW)) bus ();

    gpu_raster_engine #(
        .WIDTH(WIDTH), .HEIGHT(HEIGHT), .XW(XW), .YW(YW), .RD_LAT(RD_LAT)
    ) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus)
    );

    // Framebuffer model with a one-cycle read pipeline and a bulk pattern loader.
    logic       ram  [NPIX];
    logic       snap [NPIX];
    logic       init_go = 1'b0;
    logic [1:0] init_mode = 2'd0;

    function automatic int idx(input int x, input int y);
        return y * WIDTH + x;
    endfunction

    function automatic logic pat(input logic [1:0] m, input int i);
        int x, y;
        x = i % WIDTH;
        y = i / WIDTH;
        case (m)
            2'd1:    return logic'(((x * 7) ^ (y * 13) ^ (x >> 2)) & 1);
            2'd2:    return logic'((x + y) & 1);
            default: return 1'b0;
        endcase
    endfunction

    always @(posedge clk) begin
        if (init_go) begin
            for (int i = 0; i < NPIX; i++) ram[i] <= pat(init_mode, i);
            bus.mem_rd_data <= 1'b0;
        end else begin
            if (bus.mem_wr_en) ram[idx(int'(bus.mem_x), int'(bus.mem_y))] <= bus.mem_wr_data;
            if (bus.mem_rd_en) bus.mem_rd_data <= ram[idx(int'(bus.mem_x), int'(bus.mem_y))];
        end
    end

    typedef struct { bit wr; int x; int y; bit d; } strobe_t;
    typedef struct { bit err; int code; } done_t;
    strobe_t sq[$];
    done_t   dq[$];

    int checks = 0, errors = 0;
    int busy_cycles = 0, wr_cnt = 0, done_cnt = 0;
    bit prev_wr = 0, got_rd = 0, got_wr = 0;
    int first_rd_x, first_rd_y, first_wr_x, first_wr_y;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic bit rop_f(input int r, input bit s, input bit d);
        case (r)
            1:       return s ^ d;
            2:       return s & d;
            3:       return s | d;
            default: return s;
        endcase
    endfunction

    task automatic push_r(input int x, input int y);
        strobe_t e;
        e.wr = 0; e.x = x; e.y = y; e.d = 0;
        sq.push_back(e);
    endtask

    task automatic push_w(input int x, input int y, input bit d);
        strobe_t e;
        e.wr = 1; e.x = x; e.y = y; e.d = d;
        sq.push_back(e);
    endtask

    task automatic push_done(input bit err, input int code);
        done_t e;
        e.err = err; e.code = code;
        dq.push_back(e);
    endtask

    // Expected strobe stream for a valid command, built from a pre-op snapshot.
    task automatic push_op(input bit op, input int rop, input bit fill,
                           input int sx, input int sy, input int dx, input int dy,
                           input int w, input int h);
        bit xr, yr, s, d;
        int ox, oy;
        for (int i = 0; i < NPIX; i++) snap[i] = ram[i];
        xr = op && (dx > sx);
        yr = op && (dy > sy);
        for (int yi = 0; yi < h; yi++) begin
            for (int xi = 0; xi < w; xi++) begin
                ox = xr ? (w - 1 - xi) : xi;
                oy = yr ? (h - 1 - yi) : yi;
                s  = op ? snap[idx(sx + ox, sy + oy)] : fill;
                d  = snap[idx(dx + ox, dy + oy)];
                if (op) push_r(sx + ox, sy + oy);
                if (rop != 0) push_r(dx + ox, dy + oy);
                push_w(dx + ox, dy + oy, rop_f(rop, s, d));
            end
        end
        push_done(0, 0);
    endtask

    task automatic monitor_step();
        strobe_t e;
        done_t   dn;
        if (bus.busy) busy_cycles++;
        if (bus.mem_rd_en || bus.mem_wr_en) begin
            chk("strobe overlap", int'(bus.mem_rd_en && bus.mem_wr_en), 0);
            checks++;
            if (sq.size() == 0) begin
                errors++;
                $display("FAIL strobe: unexpected wr=%0d at (%0d,%0d)", bus.mem_wr_en,
                         bus.mem_x, bus.mem_y);
            end else begin
                e = sq.pop_front();
                if (e.wr != bus.mem_wr_en || e.x != int'(bus.mem_x) || e.y != int'(bus.mem_y) ||
                    (e.wr && e.d != bus.mem_wr_data)) begin
                    errors++;
                    $display("FAIL strobe: got wr=%0d (%0d,%0d) d=%0d expected wr=%0d (%0d,%0d) d=%0d",
                             bus.mem_wr_en, bus.mem_x, bus.mem_y, bus.mem_wr_data,
                             e.wr, e.x, e.y, e.d);
                end
            end
            if (bus.mem_rd_en && !got_rd) begin
                got_rd = 1; first_rd_x = int'(bus.mem_x); first_rd_y = int'(bus.mem_y);
            end
            if (bus.mem_wr_en && !got_wr) begin
                got_wr = 1; first_wr_x = int'(bus.mem_x); first_wr_y = int'(bus.mem_y);
            end
        end
        if (bus.mem_wr_en) wr_cnt++;
        if (bus.done) begin
            done_cnt++;
            checks++;
            if (dq.size() == 0) begin
                errors++;
                $display("FAIL done: unexpected pulse err=%0d code=%0d", bus.error, bus.err_code);
            end else begin
                dn = dq.pop_front();
                if (dn.err != bus.error || dn.code != int'(bus.err_code)) begin
                    errors++;
                    $display("FAIL done: got err=%0d code=%0d expected err=%0d code=%0d",
                             bus.error, bus.err_code, dn.err, dn.code);
                end
                if (!dn.err) chk("done follows final write", int'(prev_wr), 1);
            end
            chk("done idle busy", int'(bus.busy), 0);
            chk("done idle ready", int'(bus.cmd_ready), 1);
        end
        prev_wr = bus.mem_wr_en;
    endtask

    task automatic issue(input bit op, input int rop, input bit fill,
                         input int sx, input int sy, input int dx, input int dy,
                         input int w, input int h);
        @(negedge clk);
        chk("cmd_ready before issue", int'(bus.cmd_ready), 1);
        busy_cycles    = 0;
        bus.cmd_op     = op;
        bus.cmd_rop    = 2'(rop);
        bus.fill_value = fill;
        bus.src_x      = XW'(sx);
        bus.src_y      = YW'(sy);
        bus.dst_x      = XW'(dx);
        bus.dst_y      = YW'(dy);
        bus.rect_w     = XW'(w);
        bus.rect_h     = YW'(h);
        bus.cmd_valid  = 1'b1;
        @(posedge clk);
        #1;
        bus.cmd_valid  = 1'b0;
        bus.dst_x      = XW'($urandom);
        bus.src_y      = YW'($urandom);
        bus.fill_value = ~fill;
        bus.cmd_rop    = 2'($urandom);
    endtask

    task automatic wait_done(input int target, input string name);
        for (int i = 0; i < 3000 && done_cnt < target; i++) @(posedge clk);
        checks++;
        if (done_cnt < target) begin
            errors++;
            $display("FAIL %s: no done pulse, got %0d expected %0d", name, done_cnt, target);
        end
        chk({name, " leftover strobes"}, sq.size(), 0);
    endtask

    task automatic load(input logic [1:0] m);
        @(negedge clk);
        init_mode = m;
        init_go   = 1'b1;
        @(posedge clk);
        #1 init_go = 1'b0;
    endtask

    // mode 0: dst == snap src, 1: dst == ~snap dst, 2: dst == value
    task automatic chk_rect(input string name, input int mode, input bit v,
                            input int sx, input int sy, input int dx, input int dy,
                            input int w, input int h);
        int bad = 0;
        bit want;
        for (int y = 0; y < h; y++)
            for (int x = 0; x < w; x++) begin
                case (mode)
                    0:       want = snap[idx(sx + x, sy + y)];
                    1:       want = ~snap[idx(dx + x, dy + y)];
                    default: want = v;
                endcase
                if (ram[idx(dx + x, dy + y)] != want) bad++;
            end
        chk(name, bad, 0);
    endtask

    initial begin
        int d0;
        int t1x[6] = '{10, 11, 12, 10, 11, 12};
        int t1y[6] = '{5, 5, 5, 6, 6, 6};

        bus.cmd_valid = 0; bus.cmd_op = 0; bus.cmd_rop = 0; bus.fill_value = 0;
        bus.src_x = 0; bus.src_y = 0; bus.dst_x = 0; bus.dst_y = 0;
        bus.rect_w = 0; bus.rect_h = 0; bus.abort = 0;

        #2 rst_n = 1'b0;
        #1;
        chk("reset cmd_ready", int'(bus.cmd_ready), 1);
        chk("reset busy", int'(bus.busy), 0);
        chk("reset done", int'(bus.done), 0);
        chk("reset error", int'(bus.error), 0);
        chk("reset err_code", int'(bus.err_code), 0);
        chk("reset strobes", int'({bus.mem_rd_en, bus.mem_wr_en, bus.mem_wr_data}), 0);
        chk("reset addr", int'({bus.mem_x, bus.mem_y}), 0);

        fork
            forever begin
                @(negedge clk);
                monitor_step();
            end
        join_none

        load(2'd1);
        @(negedge clk) rst_n = 1'b1;

        // 1: FILL COPY, one write per cycle in row-major order
        for (int i = 0; i < 6; i++) push_w(t1x[i], t1y[i], 1'b1);
        push_done(0, 0);
        d0 = done_cnt;
        issue(0, 0, 1, 0, 0, 10, 5, 3, 2);
        wait_done(d0 + 1, "t1 fill");
        chk("t1 busy cycles", busy_cycles, 6);
        for (int i = 0; i < NPIX; i++) snap[i] = ram[i];
        chk_rect("t1 rect", 2, 1'b1, 0, 0, 10, 5, 3, 2);

        // 2: BLIT COPY, non-overlapping
        push_op(1, 0, 0, 0, 0, 100, 50, 4, 4);
        d0 = done_cnt;
        issue(1, 0, 0, 0, 0, 100, 50, 4, 4);
        wait_done(d0 + 1, "t2 blit");
        chk("t2 busy cycles", busy_cycles, 48);
        chk_rect("t2 rect", 0, 1'b0, 0, 0, 100, 50, 4, 4);
        chk("t2 error level", int'(bus.error), 0);

        // 3: overlapping BLIT scans right-to-left, bottom-to-top
        push_op(1, 0, 0, 10, 10, 12, 11, 8, 8);
        got_rd = 0; got_wr = 0;
        d0 = done_cnt;
        issue(1, 0, 0, 10, 10, 12, 11, 8, 8);
        wait_done(d0 + 1, "t3 overlap");
        chk("t3 first read x", first_rd_x, 17);
        chk("t3 first read y", first_rd_y, 17);
        chk("t3 first write x", first_wr_x, 19);
        chk("t3 first write y", first_wr_y, 18);
        chk_rect("t3 rect", 0, 1'b0, 10, 10, 12, 11, 8, 8);

        // 4: FILL XOR over a checkerboard inverts it
        load(2'd2);
        push_op(0, 1, 1, 0, 0, 20, 20, 5, 3);
        d0 = done_cnt;
        issue(0, 1, 1, 0, 0, 20, 20, 5, 3);
        wait_done(d0 + 1, "t4 xor");
        chk("t4 busy cycles", busy_cycles, 45);
        chk_rect("t4 rect", 1, 1'b0, 0, 0, 20, 20, 5, 3);

        // 5: rejections and an exact-fit rectangle at the screen corner
        push_done(1, 2);
        d0 = done_cnt;
        issue(0, 0, 1, 0, 0, 5, 5, 0, 3);
        wait_done(d0 + 1, "t5 zero size");
        chk("t5 zero busy cycles", busy_cycles, 0);
        chk("t5 zero err level", int'(bus.err_code), 2);
        push_done(1, 1);
        d0 = done_cnt;
        issue(0, 0, 1, 0, 0, 318, 0, 4, 1);
        wait_done(d0 + 1, "t5 dst oob");
        push_done(1, 1);
        d0 = done_cnt;
        issue(1, 0, 0, 0, 199, 0, 0, 2, 2);
        wait_done(d0 + 1, "t5 src oob");
        chk("t5 oob busy cycles", busy_cycles, 0);
        push_op(0, 0, 0, 0, 0, 316, 199, 4, 1);
        d0 = done_cnt;
        issue(0, 0, 0, 0, 0, 316, 199, 4, 1);
        wait_done(d0 + 1, "t5 exact fit");
        chk("t5 error cleared", int'(bus.error), 0);

        // 6a: abort during the fifth write of a long FILL
        for (int i = 0; i < 5; i++) push_w(i, 100, 1'b1);
        push_done(1, 3);
        d0 = done_cnt;
        wr_cnt = 0;
        issue(0, 0, 1, 0, 0, 0, 100, 20, 2);
        for (int i = 0; i < 200 && wr_cnt < 5; i++) begin
            @(negedge clk);
            #1;
        end
        bus.abort = 1'b1;
        @(posedge clk);
        #1 bus.abort = 1'b0;
        wait_done(d0 + 1, "t6 abort");
        repeat (4) @(posedge clk);
        chk("t6 writes after abort", wr_cnt, 5);
        chk("t6 err_code level", int'(bus.err_code), 3);

        // 6b: abort in IDLE is ignored
        d0 = done_cnt;
        @(negedge clk) bus.abort = 1'b1;
        repeat (2) @(negedge clk);
        bus.abort = 1'b0;
        repeat (3) @(posedge clk);
        chk("t6 idle abort no done", done_cnt, d0);

        // 6c: asynchronous reset mid-BLIT
        push_op(1, 0, 0, 0, 0, 200, 100, 8, 8);
        issue(1, 0, 0, 0, 0, 200, 100, 8, 8);
        repeat (10) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("rst mid busy", int'(bus.busy), 0);
        chk("rst mid ready", int'(bus.cmd_ready), 1);
        chk("rst mid strobes", int'({bus.mem_rd_en, bus.mem_wr_en, bus.mem_wr_data}), 0);
        chk("rst mid addr", int'({bus.mem_x, bus.mem_y}), 0);
        chk("rst mid status", int'({bus.done, bus.error, bus.err_code}), 0);
        sq.delete();
        dq.delete();
        @(negedge clk) rst_n = 1'b1;

        // recovery after reset
        push_op(0, 0, 1, 0, 0, 0, 0, 2, 1);
        d0 = done_cnt;
        issue(0, 0, 1, 0, 0, 0, 0, 2, 1);
        wait_done(d0 + 1, "recovery");
        chk("recovery busy cycles", busy_cycles, 2);

        repeat (2) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
